pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width; SHALL be a positive multiple of SEG.
REQ-002 Parameter SEG, default 4, carry-segment width per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry-out of the MSB.

Function
REQ-013 Accept: a beat SHALL be accepted when in_valid && in_ready.
REQ-014 Compute: sum/cout SHALL equal {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-015 Stage k (0..STAGES-1) SHALL add slice k of a and b plus the registered carry from stage k-1; stage 0 uses cin.
REQ-016 Operand skew: slices k>0 SHALL be delayed k cycles before their stage; sum slices SHALL be deskewed so all WIDTH bits emerge together.
REQ-017 Latency: with out_ready=1, the result SHALL be presented STAGES cycles after acceptance.
REQ-018 Throughput: one beat per cycle when out_ready=1.
REQ-019 Advance: adv = !out_valid || out_ready; every pipeline register, valid bit and skew/deskew register SHALL update only when adv=1.
REQ-020 in_ready SHALL equal adv (combinational from out_valid and out_ready, never from in_valid).
REQ-021 Stall: while out_valid && !out_ready, sum, cout and out_valid SHALL stay stable and no beat SHALL be lost, duplicated or reordered.
REQ-022 Bubbles: in_valid=0 while adv=1 SHALL insert an invalid slot; bubbles SHALL not produce out_valid.
REQ-023 Ordering: results SHALL leave in acceptance order.
REQ-024 Boundary: a carry generated in slice 0 SHALL propagate through all slices (e.g. 0xFFFF+1); cout SHALL be the carry out of slice STAGES-1.

Reset
REQ-025 rst_n low SHALL clear all valid bits immediately; out_valid=0, sum=0, cout=0 (and ovf=0 when present).
REQ-026 Datapath registers other than outputs MAY be left unreset; in-flight beats at reset SHALL be discarded and never emerge.
REQ-027 in_ready SHALL be 1 during and after reset (follows REQ-020 with out_valid=0).

Configuration
REQ-028 Macro PIPELINED_ADDER_SUB_EN defined: add input sub (1, sampled with a/b) and output ovf (1, aligned with sum).
REQ-029 With the macro: sub=1 SHALL compute a + ~b + 1 + (cin? 0 : 0) i.e. a - b, cin ignored; sub=0 behaves as REQ-014; ovf SHALL be the two's-complement signed overflow of the operation; sub SHALL travel down the pipe with its beat.
REQ-030 Without the macro: no sub/ovf ports, no related logic; behaviour exactly REQ-014.

Structure
REQ-031 Package pipelined_adder_pkg SHALL hold default WIDTH/SEG constants and a function computing STAGES.
REQ-032 One sub-module pipelined_adder_stage (one SEG slice add plus its carry register, enable=adv), instantiated STAGES times via generate.
REQ-033 Elaboration SHALL fail if WIDTH % SEG != 0.

Verification (WIDTH=16, SEG=4, STAGES=4 unless noted)
REQ-034 a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> 4 cycles later sum=0x0000, cout=1, out_valid=1 for one cycle.
REQ-035 Beats (0x1234+0x1111), (0x00FF+0x0001,cin=1), (0x8000+0x8000) back-to-back -> 0x2345/0, 0x0101/0, 0x0000/1 on consecutive cycles 4,5,6.
REQ-036 Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, sum/cout frozen; release -> remaining beats emerge in order, none lost or repeated.
REQ-037 rst_n low for 1 cycle with 2 beats in flight -> out_valid=0 immediately; after release no result appears without new input.
REQ-038 With PIPELINED_ADDER_SUB_EN: 0x0005-0x0007 -> sum=0xFFFE, ovf=0; 0x8000-0x0001 -> sum=0x7FFF, ovf=1.
REQ-039 WIDTH=8, SEG=8 -> STAGES=1, 0xF0+0x20 -> sum=0x10, cout=1 after 1 cycle; random add/stall mix vs. reference model, zero mismatches.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: default sizing and stage-count helper for the
// segmented-carry pipelined adder.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SEG   = 4;

  // Number of carry segments (one pipeline stage per segment).
  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// pipelined_adder_stage: one SEG-bit slice add with its registered sum
// slice and registered carry-out, advancing only when en is high.
module pipelined_adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int SEG = DEFAULT_SEG
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] sum,
  output logic           co
);

  logic [SEG:0] total;

  // Slice sum including the carry from the previous segment.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
  end

  // Register the slice result and its carry for the next stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      co  <= 1'b0;
    end else if (en) begin
      {co, sum} <= total;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into WIDTH/SEG carry segments,
// one segment per pipeline stage, with operand skew and sum deskew so all
// bits of a result emerge together. Valid/ready handshake with full-pipe
// stall. Optional macro PIPELINED_ADDER_SUB_EN adds a sub input (a - b)
// and a signed overflow output ovf.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  if (WIDTH % SEG != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be a multiple of SEG");
  end

  logic              adv;
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [STAGES-1:0] carry;
  logic [STAGES-1:0] stage_ci;
  logic [SEG-1:0]    stage_a   [STAGES];
  logic [SEG-1:0]    stage_b   [STAGES];
  logic [SEG-1:0]    stage_sum [STAGES];

  assign out_valid = vld[STAGES-1];
  assign in_ready  = adv;
  assign cout      = carry[STAGES-1];

  // The whole pipe moves together whenever the output slot is free or drained.
  always_comb begin
    adv = !out_valid || out_ready;
  end

  // Subtraction is folded in at acceptance as a + ~b + 1, so the beat's
  // mode travels down the pipe inside its operands and carry-in.
  always_comb begin
    b_eff = b;
    c0    = cin;
`ifdef PIPELINED_ADDER_SUB_EN
    if (sub) begin
      b_eff = ~b;
      c0    = 1'b1;
    end
`endif
  end

  // Valid bits shift with the data; bubbles enter as zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (adv) begin
      vld <= STAGES'({vld, in_valid});
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stage_a[k]  = a[SEG-1:0];
      assign stage_b[k]  = b_eff[SEG-1:0];
      assign stage_ci[k] = c0;
    end else begin : g_skew
      logic [SEG-1:0] a_skew [k];
      logic [SEG-1:0] b_skew [k];

      // Delay operand slice k by k cycles so it meets its carry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            a_skew[j] <= '0;
            b_skew[j] <= '0;
          end
        end else if (adv) begin
          a_skew[0] <= a[k*SEG +: SEG];
          b_skew[0] <= b_eff[k*SEG +: SEG];
          for (int j = 1; j < k; j++) begin
            a_skew[j] <= a_skew[j-1];
            b_skew[j] <= b_skew[j-1];
          end
        end
      end

      assign stage_a[k]  = a_skew[k-1];
      assign stage_b[k]  = b_skew[k-1];
      assign stage_ci[k] = carry[k-1];
    end

    pipelined_adder_stage #(
      .SEG (SEG)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .a     (stage_a[k]),
      .b     (stage_b[k]),
      .ci    (stage_ci[k]),
      .sum   (stage_sum[k]),
      .co    (carry[k])
    );

    if (k < STAGES - 1) begin : g_deskew
      localparam int DLY = STAGES - 1 - k;
      logic [SEG-1:0] dly [DLY];

      // Hold early sum slices until the last segment finishes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < DLY; j++) begin
            dly[j] <= '0;
          end
        end else if (adv) begin
          dly[0] <= stage_sum[k];
          for (int j = 1; j < DLY; j++) begin
            dly[j] <= dly[j-1];
          end
        end
      end

      assign sum[k*SEG +: SEG] = dly[DLY-1];
    end else begin : g_direct
      assign sum[k*SEG +: SEG] = stage_sum[k];
    end
  end

`ifdef PIPELINED_ADDER_SUB_EN
  logic a_msb_q;
  logic b_msb_q;

  // Capture operand sign bits alongside the top slice for overflow detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (adv) begin
      a_msb_q <= stage_a[STAGES-1][SEG-1];
      b_msb_q <= stage_b[STAGES-1][SEG-1];
    end
  end

  assign ovf = (a_msb_q == b_msb_q) && (sum[WIDTH-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: self-checking bench for pipelined_adder using a
// slot-level reference model (results computed with plain arithmetic).
// Honours PIPELINED_ADDER_SUB_EN when defined.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int SEG    = 4;
  localparam int STAGES = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPELINED_ADDER_SUB_EN
  logic             sub;
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  logic             mv [STAGES];
  logic [WIDTH:0]   mr [STAGES];
  logic             mo [STAGES];

  pipelined_adder #(
    .WIDTH (WIDTH),
    .SEG   (SEG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub       (sub),
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  // {cout,sum} as a + b + cin, or a + ~b + 1 when subtracting.
  function automatic logic [WIDTH:0] refSum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic c, input logic s);
    logic [WIDTH-1:0] ny;
    ny = ~y;
    if (s) return {1'b0, x} + {1'b0, ny} + (WIDTH+1)'(1);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // Signed overflow: true result outside the WIDTH-bit two's-complement range.
  function automatic logic refOvf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic c, input logic s);
    longint sx, sy, r, lim;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    lim = longint'(1) <<< (WIDTH - 1);
    r   = s ? (sx - sy) : (sx + sy + longint'(c));
    return (r > lim - 1) || (r < -lim);
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < STAGES; i++) begin
      mv[i] = 1'b0;
      mr[i] = '0;
      mo[i] = 1'b0;
    end
  endtask

  task automatic checkOutput();
    checkVal("out_valid", {63'b0, out_valid}, {63'b0, mv[STAGES-1]});
    if (mv[STAGES-1]) begin
      checkVal("sum", {48'b0, sum}, {48'b0, mr[STAGES-1][WIDTH-1:0]});
      checkVal("cout", {63'b0, cout}, {63'b0, mr[STAGES-1][WIDTH]});
`ifdef PIPELINED_ADDER_SUB_EN
      checkVal("ovf", {63'b0, ovf}, {63'b0, mo[STAGES-1]});
`endif
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                               input logic c, input logic s, input logic ordy);
    logic adv_m;
    in_valid  = v;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = ordy;
`ifdef PIPELINED_ADDER_SUB_EN
    sub       = s;
`endif
    adv_m = !mv[STAGES-1] || ordy;
    #1;
    checkVal("in_ready", {63'b0, in_ready}, {63'b0, adv_m});
    @(posedge clk);
    if (adv_m) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mr[i] = mr[i-1];
        mo[i] = mo[i-1];
      end
      mv[0] = v;
      mr[0] = refSum(x, y, c, s);
      mo[0] = refOvf(x, y, c, s);
    end
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic rs;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_out_valid", {63'b0, out_valid}, 64'd0);
    checkVal("rst_sum", {48'b0, sum}, 64'd0);
    checkVal("rst_cout", {63'b0, cout}, 64'd0);
    checkVal("rst_in_ready", {63'b0, in_ready}, 64'd1);
    rst_n = 1'b1;

    // Full-width carry ripple, result four cycles after acceptance.
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    idle(3);
    checkVal("ripple_valid", {63'b0, out_valid}, 64'd1);
    checkVal("ripple_sum", {48'b0, sum}, 64'h0000);
    checkVal("ripple_cout", {63'b0, cout}, 64'd1);
    idle(1);
    checkVal("ripple_one_cycle", {63'b0, out_valid}, 64'd0);

    // Back-to-back beats emerge on consecutive cycles.
    applyStimulus(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkVal("b2b_sum0", {47'b0, cout, sum}, {47'b0, 1'b0, 16'h2345});
    idle(1);
    checkVal("b2b_sum1", {47'b0, cout, sum}, {47'b0, 1'b0, 16'h0101});
    idle(1);
    checkVal("b2b_sum2", {47'b0, cout, sum}, {47'b0, 1'b1, 16'h0000});
    idle(2);

    // Fill the pipe, stall three cycles, then drain in order.
    for (int i = 0; i < STAGES; i++) applyStimulus(1'b1, WIDTH'(16'h0100 * (i + 1)), WIDTH'(i + 3), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0);
      checkVal("stall_hold_sum", {48'b0, sum}, 64'h0103);
    end
    idle(STAGES + 1);

    // Reset with beats in flight discards them.
    for (int i = 0; i < STAGES; i++) applyStimulus(1'b1, 16'h0F0F, WIDTH'(i), 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkVal("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    checkVal("mid_rst_sum", {48'b0, sum}, 64'd0);
    checkVal("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearModel();
    idle(STAGES + 2);

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtraction and signed overflow.
    applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    idle(2);
    checkVal("sub_sum0", {48'b0, sum}, 64'hFFFE);
    checkVal("sub_ovf0", {63'b0, ovf}, 64'd0);
    idle(1);
    checkVal("sub_sum1", {48'b0, sum}, 64'h7FFF);
    checkVal("sub_ovf1", {63'b0, ovf}, 64'd1);
    idle(2);
`endif

    // Random traffic with bubbles and back-pressure.
    for (int i = 0; i < 400; i++) begin
      rs = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      applyStimulus(($urandom_range(0, 9) < 7), WIDTH'($urandom), WIDTH'($urandom),
                    1'($urandom_range(0, 1)), rs, ($urandom_range(0, 9) < 6));
    end
    idle(STAGES + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
